// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
// Provides default sizing, overlap-mode encodings, the fill-counter width
// helper and the pattern-length legality check used at elaboration.
package seq_det_pkg;

  // Default pattern length and match-counter width (legacy "000" detector)
  localparam int DEF_PAT_W = 3;
  localparam int DEF_CNT_W = 8;

  // Encoding of the runtime overlap input
  localparam logic MODE_OVERLAP    = 1'b1;
  localparam logic MODE_NONOVERLAP = 1'b0;

  // Width of the fill counter; it must hold 0..pat_w-1
  function automatic int fill_w_f(input int pat_w);
    return $clog2(pat_w);
  endfunction

  // Fill width for the default pattern length
  localparam int DEF_FILL_W = fill_w_f(DEF_PAT_W);

  // Supported pattern lengths are 2..16
  function automatic bit pat_w_legal_f(input int pat_w);
    return (pat_w >= 2) && (pat_w <= 16);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports: clock - rising-edge clock; reset - synchronous active-high reset;
//        clr - synchronous clear; inc - count enable; cnt - current count,
//        sticks at all-ones and never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count register: reset/clear to zero, increment until saturated
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with valid qualifier,
// runtime overlap/non-overlap mode, soft clear and saturating match count.
// Ports: clock, reset (sync, active-high); in - serial bit; in_valid - bit
//        qualifier; overlap - 1 reuses matched bits, 0 restarts after a
//        match; clear - soft clear of history and count; out - combinational
//        match flag; out_q - out delayed one cycle; match_cnt - saturating
//        match count; fill - number of valid history bits (0..PAT_W-1).
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = {PAT_W{1'b0}},
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in,
  input  logic                         in_valid,
  input  logic                         overlap,
  input  logic                         clear,
  output logic                         out,
  output logic                         out_q,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [fill_w_f(PAT_W)-1:0]   fill
);

  localparam int               FILL_W   = fill_w_f(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  if (!pat_w_legal_f(PAT_W)) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W must be in 2..16");
  end

  logic [PAT_W-2:0]  hist_r;
  logic [PAT_W-2:0]  hist_nxt_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [PAT_W-1:0]  window_s;
  logic              hit_s;
  logic              out_q_r;

  // Match detection on the stored history plus the incoming bit
  always_comb begin
    window_s = {hist_r, in};
    hit_s    = 1'b0;
    // fill gate keeps the zeroed history from matching right after reset
    if (in_valid && !reset && !clear && (fill_r == FILL_MAX) &&
        (window_s == PATTERN)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next history and fill values
  always_comb begin
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    if (clear) begin
      hist_nxt_s = {(PAT_W-1){1'b0}};
      fill_nxt_s = {FILL_W{1'b0}};
    end else if (in_valid) begin
      // the oldest bit falls off the top; works for PAT_W=2 as well
      hist_nxt_s = window_s[PAT_W-2:0];
      if (hit_s && (overlap == MODE_NONOVERLAP)) begin
        fill_nxt_s = {FILL_W{1'b0}};
      end else if (fill_r != FILL_MAX) begin
        fill_nxt_s = fill_r + FILL_W'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end
  end

  // History, fill and delayed match registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_r  <= {(PAT_W-1){1'b0}};
      fill_r  <= {FILL_W{1'b0}};
      out_q_r <= 1'b0;
    end else begin
      hist_r  <= hist_nxt_s;
      fill_r  <= fill_nxt_s;
      out_q_r <= hit_s;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (hit_s),
    .cnt   (match_cnt)
  );

  assign out   = hit_s;
  assign out_q = out_q_r;
  assign fill  = fill_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. Three instances share the
// stimulus: default (3-bit 000), 4-bit 1011, and 3-bit 000 with a 2-bit
// counter. A reference model computes expected out combinationally and
// pushes the expected post-edge state to a scoreboard queue.
module tb_seq_detector_param;

  logic clock;
  logic reset;
  logic in;
  logic in_valid;
  logic overlap;
  logic clear;

  logic       out0, out1, out2;
  logic       oq0, oq1, oq2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [1:0] fill0, fill1, fill2;

  int total;
  int bad;
  int cyc;

  seq_detector_param u_dut0 (
    .clock (clock), .reset (reset), .in (in), .in_valid (in_valid),
    .overlap (overlap), .clear (clear), .out (out0), .out_q (oq0),
    .match_cnt (cnt0), .fill (fill0)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut1 (
    .clock (clock), .reset (reset), .in (in), .in_valid (in_valid),
    .overlap (overlap), .clear (clear), .out (out1), .out_q (oq1),
    .match_cnt (cnt1), .fill (fill1)
  );

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b000), .CNT_W(2)) u_dut2 (
    .clock (clock), .reset (reset), .in (in), .in_valid (in_valid),
    .overlap (overlap), .clear (clear), .out (out2), .out_q (oq2),
    .match_cnt (cnt2), .fill (fill2)
  );

  logic [2:0]      out_w;
  logic [2:0]      oq_w;
  logic [2:0][7:0] cnt_w;
  logic [2:0][3:0] fill_w;

  assign out_w     = {out2, out1, out0};
  assign oq_w      = {oq2, oq1, oq0};
  assign cnt_w[0]  = cnt0;
  assign cnt_w[1]  = cnt1;
  assign cnt_w[2]  = {6'd0, cnt2};
  assign fill_w[0] = {2'd0, fill0};
  assign fill_w[1] = {2'd0, fill1};
  assign fill_w[2] = {2'd0, fill2};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model configuration and state
  int          patw [3] = '{3, 4, 3};
  logic [15:0] pat  [3] = '{16'h0000, 16'h000B, 16'h0000};
  int          cmax [3] = '{255, 255, 3};
  logic [15:0] m_sr [3];
  int          m_n  [3];
  int          m_cnt[3];

  typedef struct packed {
    logic [2:0]      oq;
    logic [2:0][7:0] cnt;
    logic [2:0][3:0] fill;
  } sb_t;

  sb_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic model_hit(input int i, input logic b, input logic v,
                                     input logic cl, input logic rs);
    logic [16:0] w;
    logic [16:0] mask;
    w    = {m_sr[i], b};
    mask = (17'd1 << patw[i]) - 17'd1;
    return v && !cl && !rs && (m_n[i] == patw[i] - 1) &&
           ((w & mask) == {1'b0, pat[i]});
  endfunction

  task automatic step(input logic b, input logic v, input logic ov,
                      input logic cl, input logic rs);
    sb_t  e;
    sb_t  got;
    logic h;
    @(negedge clock);
    in = b; in_valid = v; overlap = ov; clear = cl; reset = rs;
    #1;
    for (int i = 0; i < 3; i++) begin
      h = model_hit(i, b, v, cl, rs);
      check_val($sformatf("out%0d", i), {31'd0, out_w[i]}, {31'd0, h});
      if (rs || cl) begin
        m_sr[i] = 16'd0; m_n[i] = 0; m_cnt[i] = 0;
      end else if (v) begin
        m_sr[i] = {m_sr[i][14:0], b};
        if (h && !ov) m_n[i] = 0;
        else if (m_n[i] < patw[i] - 1) m_n[i]++;
        if (h && (m_cnt[i] < cmax[i])) m_cnt[i]++;
      end
      e.oq[i]   = h;
      e.cnt[i]  = m_cnt[i][7:0];
      e.fill[i] = m_n[i][3:0];
    end
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
    e = sb_q.pop_front();
    got.oq = oq_w; got.cnt = cnt_w; got.fill = fill_w;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("out_q%0d", i), {31'd0, got.oq[i]}, {31'd0, e.oq[i]});
      check_val($sformatf("cnt%0d", i), {24'd0, got.cnt[i]}, {24'd0, e.cnt[i]});
      check_val($sformatf("fill%0d", i), {28'd0, got.fill[i]}, {28'd0, e.fill[i]});
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [6:0] s1011;

  initial begin
    total = 0; bad = 0; cyc = 0;
    in = 1'b0; in_valid = 1'b0; overlap = 1'b0; clear = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_sr[i] = 16'd0; m_n[i] = 0; m_cnt[i] = 0;
    end

    // Reset state, with in_valid high to show out stays low under reset
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Legacy: non-overlapping zeros
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("legacy_cnt", {24'd0, cnt0}, 32'd2);

    // Overlapping zeros, then two more to saturate the 2-bit counter
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("ovl_cnt", {24'd0, cnt0}, 32'd4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("ovl8_cnt", {24'd0, cnt0}, 32'd6);
    check_val("sat_cnt", {30'd0, cnt2}, 32'd3);

    // 1011 pattern, overlapping then non-overlapping
    s1011 = 7'b1011011;
    do_reset();
    for (int k = 6; k >= 0; k--) step(s1011[k], 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("p1011_ovl_cnt", {24'd0, cnt1}, 32'd2);
    do_reset();
    for (int k = 6; k >= 0; k--) step(s1011[k], 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("p1011_novl_cnt", {24'd0, cnt1}, 32'd1);

    // Valid gaps
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("gap_fill", {30'd0, fill0}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("gap_cnt", {24'd0, cnt0}, 32'd1);

    // Clear mid-pattern, then the same with reset
    for (int r = 0; r < 2; r++) begin
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, (r == 0), (r == 1));
      check_val("clr_fill", {30'd0, fill0}, 32'd0);
      check_val("clr_cnt", {24'd0, cnt0}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("clr_nohit", {24'd0, cnt0}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("clr_hit", {24'd0, cnt0}, 32'd1);
    end

    // Random traffic with occasional clear/reset and mode flips
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
